// File: rtl/demux8_pkg.sv
// Shared lane constants and target decode for the 1-to-8 registered demux.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable; consumers apply their own flow control.
package demux8_pkg;

    localparam int NumLanes = 8;
    localparam int SelWidth = 3;

    // Lane index naming, matches the a_o..h_o output ordering.
    typedef enum logic [SelWidth-1:0] {
        LANE_A = 3'd0,
        LANE_B = 3'd1,
        LANE_C = 3'd2,
        LANE_D = 3'd3,
        LANE_E = 3'd4,
        LANE_F = 3'd5,
        LANE_G = 3'd6,
        LANE_H = 3'd7
    } lane_e;

    // One-hot lane mask for a unicast select, or all lanes on broadcast.
    function automatic logic [NumLanes-1:0] lane_target(
        input logic [SelWidth-1:0] sel,
        input logic                bcast
    );
        logic [NumLanes-1:0] tgt;
        tgt = '0;
        if (bcast) begin
            tgt = '1;
        end else begin
            tgt[sel] = 1'b1;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot for a single demux output lane.
// Latency: 1 clock from load_i to valid_o/data_o.
// Backpressure: can_load_o high when empty or draining; held contents frozen while stalled.
module demux_slot #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic             can_load_o
);

    logic             valid_q;
    logic             valid_d;
    logic [Width-1:0] data_q;
    logic [Width-1:0] data_d;

    // The slot can take a new word if it is empty or its current word leaves this cycle.
    assign can_load_o = !valid_q || ready_i;
    assign valid_o    = valid_q;
    assign data_o     = data_q;

    // Next state: load wins over drain so a same-cycle drain+load keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            // Data deliberately holds its last value once drained.
            valid_d = 1'b0;
        end
    end

    // Slot registers; reset discards any pending word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/demux8_16.sv
// Registered 1-to-8 demultiplexer with per-lane one-entry slots and broadcast.
// Latency: 1 clock from accepted input to lane outputs.
// Backpressure: ready_o follows the targeted slot(s); broadcast waits for all eight lanes.
module demux8_16
    import demux8_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SelWidth-1:0] sel_i,
    input  logic                bcast_i,
    input  logic [Width-1:0]    data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [Width-1:0]    a_o,
    output logic [Width-1:0]    b_o,
    output logic [Width-1:0]    c_o,
    output logic [Width-1:0]    d_o,
    output logic [Width-1:0]    e_o,
    output logic [Width-1:0]    f_o,
    output logic [Width-1:0]    g_o,
    output logic [Width-1:0]    h_o,
    output logic [NumLanes-1:0] valid_o,
    input  logic [NumLanes-1:0] ready_i
);

    logic [NumLanes-1:0] target;
    logic [NumLanes-1:0] can_load;
    logic [NumLanes-1:0] load;
    logic                accept;
    logic [Width-1:0]    lane_dat [NumLanes];

    // Target decode and ready reduction; broadcast is all-or-nothing.
    always_comb begin
        target = lane_target(sel_i, bcast_i);
        if (bcast_i) begin
            ready_o = &can_load;
        end else begin
            ready_o = can_load[sel_i];
        end
        accept = valid_i && ready_o;
        load   = target & {NumLanes{accept}};
    end

    // One holding slot per lane so a stalled lane only blocks traffic aimed at it.
    for (genvar g = 0; g < NumLanes; g++) begin : g_lane
        demux_slot #(
            .Width (Width)
        ) u_slot (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (load[g]),
            .data_i     (data_i),
            .ready_i    (ready_i[g]),
            .valid_o    (valid_o[g]),
            .data_o     (lane_dat[g]),
            .can_load_o (can_load[g])
        );
    end

    assign a_o = lane_dat[int'(LANE_A)];
    assign b_o = lane_dat[int'(LANE_B)];
    assign c_o = lane_dat[int'(LANE_C)];
    assign d_o = lane_dat[int'(LANE_D)];
    assign e_o = lane_dat[int'(LANE_E)];
    assign f_o = lane_dat[int'(LANE_F)];
    assign g_o = lane_dat[int'(LANE_G)];
    assign h_o = lane_dat[int'(LANE_H)];

endmodule

// File: tb/tb_demux8_16.sv
// Scoreboard bench for the 1-to-8 registered demux.
// Latency: expects accepted words on their lane one clock later.
// Backpressure: drives per-lane ready_i patterns and predicts ready_o from its own slot model.
module tb_demux8_16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  sel_i;
    logic        bcast_i;
    logic [15:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o;
    logic [7:0]  valid_o;
    logic [7:0]  ready_i;

    logic [15:0] lane_o [8];

    int errs   = 0;
    int checks = 0;

    // Scoreboard: per-lane queue of words expected to leave, plus last word loaded.
    logic [15:0] exp_q [8][$];
    logic [15:0] last_dat [8];
    logic        known = 1'b0;

    always #5 clk_i = ~clk_i;

    demux8_16 #(.Width(16)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sel_i   (sel_i),
        .bcast_i (bcast_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_o     (a_o),
        .b_o     (b_o),
        .c_o     (c_o),
        .d_o     (d_o),
        .e_o     (e_o),
        .f_o     (f_o),
        .g_o     (g_o),
        .h_o     (h_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    assign lane_o[0] = a_o;
    assign lane_o[1] = b_o;
    assign lane_o[2] = c_o;
    assign lane_o[3] = d_o;
    assign lane_o[4] = e_o;
    assign lane_o[5] = f_o;
    assign lane_o[6] = g_o;
    assign lane_o[7] = h_o;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one clock of stimulus, check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input logic r, input logic v, input logic [2:0] s, input logic b,
                         input logic [15:0] d, input logic [7:0] rd);
        logic [7:0]  can;
        logic        exp_rdy;
        logic [7:0]  tgt;
        logic [15:0] w;
        rst_i   = r;
        valid_i = v;
        sel_i   = s;
        bcast_i = b;
        data_i  = d;
        ready_i = rd;
        @(negedge clk_i);
        for (int k = 0; k < 8; k++) begin
            can[k] = (exp_q[k].size() == 0) || rd[k];
        end
        exp_rdy = b ? (&can) : can[s];
        if (known) begin
            chk("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("valid_o[%0d]", k), {31'd0, valid_o[k]},
                    {31'd0, exp_q[k].size() != 0});
                chk($sformatf("lane_hold[%0d]", k), {16'd0, lane_o[k]}, {16'd0, last_dat[k]});
            end
        end
        if (r) begin
            for (int k = 0; k < 8; k++) begin
                exp_q[k].delete();
                last_dat[k] = 16'h0000;
            end
            known = 1'b1;
        end else if (known) begin
            for (int k = 0; k < 8; k++) begin
                if (exp_q[k].size() != 0 && rd[k]) begin
                    w = exp_q[k].pop_front();
                    chk($sformatf("drain_dat[%0d]", k), {16'd0, lane_o[k]}, {16'd0, w});
                end
            end
            if (v && exp_rdy) begin
                tgt = b ? 8'hFF : (8'h01 << s);
                for (int k = 0; k < 8; k++) begin
                    if (tgt[k]) begin
                        exp_q[k].push_back(d);
                        last_dat[k] = d;
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [2:0]  rs;
        logic [15:0] rw;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        sel_i   = 3'd0;
        bcast_i = 1'b0;
        data_i  = 16'h0000;
        ready_i = 8'hFF;
        @(posedge clk_i);
        #1;

        // Reset for two clocks, then unicast to lane 3.
        cycle(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);
        cycle(1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);
        chk("rst_vld", {24'd0, valid_o}, 32'h0);
        chk("rst_d", {16'd0, d_o}, 32'h0);
        cycle(1'b0, 1'b1, 3'd3, 1'b0, 16'hBEEF, 8'hFF);
        chk("uni_vld", {24'd0, valid_o}, 32'h08);
        chk("uni_d", {16'd0, d_o}, 32'hBEEF);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);
        chk("uni_clr", {24'd0, valid_o}, 32'h00);

        // Backpressure on lane 2.
        cycle(1'b0, 1'b1, 3'd2, 1'b0, 16'h1111, 8'hFB);
        cycle(1'b0, 1'b1, 3'd2, 1'b0, 16'h2222, 8'hFB);
        chk("bp_rdy", {31'd0, ready_o}, 32'h0);
        chk("bp_hold", {16'd0, c_o}, 32'h1111);
        cycle(1'b0, 1'b1, 3'd2, 1'b0, 16'h2222, 8'hFB);
        cycle(1'b0, 1'b1, 3'd2, 1'b0, 16'h2222, 8'hFF);
        chk("bp_vld2", {31'd0, valid_o[2]}, 32'h1);
        chk("bp_dat2", {16'd0, c_o}, 32'h2222);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);

        // Lane isolation: lane 5 stalled and full, lane 0 still flows.
        cycle(1'b0, 1'b1, 3'd5, 1'b0, 16'h7777, 8'hDF);
        cycle(1'b0, 1'b1, 3'd0, 1'b0, 16'hA5A5, 8'hDF);
        chk("iso_a", {16'd0, a_o}, 32'hA5A5);
        chk("iso_f", {16'd0, f_o}, 32'h7777);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);

        // Broadcast into empty lanes, held one cycle, then drained.
        cycle(1'b0, 1'b1, 3'd6, 1'b1, 16'h00FF, 8'hFF);
        chk("bc_vld", {24'd0, valid_o}, 32'hFF);
        chk("bc_h", {16'd0, h_o}, 32'h00FF);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);

        // Broadcast blocked by stalled lane 7.
        cycle(1'b0, 1'b1, 3'd7, 1'b0, 16'h1234, 8'h7F);
        cycle(1'b0, 1'b1, 3'd0, 1'b1, 16'h5555, 8'h7F);
        chk("bc_blk_rdy", {31'd0, ready_o}, 32'h0);
        chk("bc_blk_vld", {24'd0, valid_o}, 32'h80);
        chk("bc_blk_a", {16'd0, a_o}, 32'h00FF);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);

        // Streaming: 100 back-to-back random words.
        for (int i = 0; i < 100; i++) begin
            rs = 3'($urandom_range(7));
            rw = 16'($urandom);
            cycle(1'b0, 1'b1, rs, 1'b0, rw, 8'hFF);
            chk("stream_rdy", {31'd0, ready_o}, 32'h1);
        end
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);

        // Reset mid-stream with three lanes full and a word offered.
        cycle(1'b0, 1'b1, 3'd1, 1'b0, 16'h0101, 8'h00);
        cycle(1'b0, 1'b1, 3'd4, 1'b0, 16'h0404, 8'h00);
        cycle(1'b0, 1'b1, 3'd6, 1'b0, 16'h0606, 8'h00);
        chk("mrst_pre", {24'd0, valid_o}, 32'h52);
        cycle(1'b1, 1'b1, 3'd2, 1'b0, 16'hDEAD, 8'h00);
        chk("mrst_vld", {24'd0, valid_o}, 32'h00);
        chk("mrst_b", {16'd0, b_o}, 32'h0);
        chk("mrst_c", {16'd0, c_o}, 32'h0);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
